mac_pipe_lanes: RTL
===================

Name: mac_pipe_lanes

Overview:
- Multi-lane, deeper-pipelined successor to the single pipelined MAC, used in the 2D-convolution datapath.
- LANES independent signed multiply-accumulate channels share one control path: input_valid, init_acc and init_value.
- Each lane has a configurable multiplier pipeline depth and optional saturating accumulation with sticky overflow flags.
- Provides an idle indication so the convolution controller knows when all accumulator results are final.

Parameters:
- INW, 14, signed operand width per lane.
- OUTW, 28, signed accumulator width per lane; must satisfy OUTW >= 2*INW.
- LANES, 4, number of parallel MAC channels; must be >= 1.
- MULT_STAGES, 2, register stages between multiplier and adder; must be >= 1.
- SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- input_valid  in  1  all lanes' operands are valid this cycle.
- init_acc  in  1  load init_value into every accumulator and flush in-flight products.
- init_value  in  OUTW  signed initial accumulator value, shared by all lanes.
- input0  in  LANES*INW  lane i operand A at bits [i*INW +: INW], signed.
- input1  in  LANES*INW  lane i operand B, same packing, signed.
- out  out  LANES*OUTW  lane i accumulator at bits [i*OUTW +: OUTW], signed.
- overflow  out  LANES  sticky per-lane overflow flag.
- idle  out  1  high when no valid product is in the multiplier pipeline.

Behaviour:
- Reset (reset==0 at a rising edge):
  - out = 0, overflow = 0, all pipeline data and valid bits = 0, idle = 1.
  - Reset overrides every other input, including mid-operation.
- Multiply and pipeline:
  - Per lane, prod = input0_i * input1_i (full 2*INW signed product), sign-extended to OUTW.
  - prod passes through MULT_STAGES registers.
  - A valid bit travels alongside, captured from input_valid at stage 0.
- Accumulate:
  - When the last-stage valid bit is 1, out_i <= out_i + prod_i.
  - Latency: a product presented with input_valid at edge t is reflected in out at edge t+MULT_STAGES+1.
  - With MULT_STAGES=1 this equals the original 2-edge MAC timing.
  - input_valid=0 cycles are bubbles and change nothing.
- Arithmetic:
  - The sum is formed in OUTW+1 bits; overflow occurs when the sum is outside [-2^(OUTW-1), 2^(OUTW-1)-1].
  - SATURATE=1: clamp to the max or min bound.
  - SATURATE=0: keep the low OUTW bits.
  - In both modes, overflow_i <= 1 and stays set until init_acc or reset.
- init_acc at a rising edge (priority below reset):
  - Every out_i <= init_value and overflow <= 0.
  - All pipeline valid bits are cleared; products in flight are discarded.
  - If input_valid=1 in the same cycle, that cycle's operands still enter stage 0 as valid and accumulate onto init_value. This lets the controller issue init together with the first operand.
- idle = NOR of all pipeline valid bits, including the stage-0 register. It is registered state, not a function of the current input_valid.
- No backpressure: an operand is accepted every cycle input_valid=1. Throughput is 1 per cycle per lane.
- Lanes are fully independent apart from the shared control. Overflow in one lane never affects another lane.

Test Plan:
(INW=14, OUTW=28, LANES=4, MULT_STAGES=2 unless stated)
1. Reset: hold reset=0 for 2 cycles with input_valid=1 and nonzero operands -> out all 0, overflow=0, idle=1. Release reset; nothing accumulates until a new valid cycle.
2. Basic accumulation: init_acc=1 with init_value=10 and input_valid=1, lane0 3*4. Follow with 2 more valid cycles of 3*4 -> lane0 out=46 three edges after the last input. Other lanes hold 10 + their products. idle=1 after drain.
3. Signed corners: init 0; one valid cycle with lane1 -5*7 and lane2 -8192*-8192 -> lane1 out=-35, lane2 out=67108864, overflow=0.
4. Saturation/wrap: init_value=134217628; lane0 product 200 -> SATURATE=1 gives out0=134217727, overflow[0]=1. Rerun with SATURATE=0 -> out0=-134217628, overflow[0]=1. Other lanes unaffected. A subsequent init_acc clears the flag.
5. Flush: valid input at edge k, init_acc (input_valid=0) at edge k+1 -> out stays at init_value; the in-flight product never lands; idle=1 at edge k+2.
6. Latency sweep: MULT_STAGES=1 and 4, single valid 2*3 with init 0 -> out=6 exactly at edge t+2 and t+5 respectively. Bubbles interleaved with valids in the stream are not counted.

Source files
------------

// File: rtl/mac_pipe_lanes.sv
// Multi-lane signed multiply-accumulate with a configurable product pipeline,
// optional saturating accumulation, sticky per-lane overflow and an idle flag.
module mac_pipe_lanes #(
  parameter int INW         = 14,
  parameter int OUTW        = 28,
  parameter int LANES       = 4,
  parameter int MULT_STAGES = 2,
  parameter int SATURATE    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   input_valid,
  input  logic                   init_acc,
  input  logic signed [OUTW-1:0] init_value,
  input  logic [LANES*INW-1:0]   input0,
  input  logic [LANES*INW-1:0]   input1,
  output logic [LANES*OUTW-1:0]  out,
  output logic [LANES-1:0]       overflow,
  output logic                   idle
);

  localparam int PW = 2 * INW;
  localparam int SW = OUTW + 1;
  localparam logic signed [OUTW-1:0] ACC_MAX = {1'b0, {(OUTW-1){1'b1}}};
  localparam logic signed [OUTW-1:0] ACC_MIN = {1'b1, {(OUTW-1){1'b0}}};

  function automatic logic sum_ovf(input logic signed [SW-1:0] s);
    return s[OUTW] != s[OUTW-1];
  endfunction

  function automatic logic signed [OUTW-1:0] clamp_sum(input logic signed [SW-1:0] s);
    if (SATURATE != 0 && sum_ovf(s))
      return s[OUTW] ? ACC_MIN : ACC_MAX;
    return s[OUTW-1:0];
  endfunction

  logic                   vld_p0;
  logic [MULT_STAGES-1:0] vld_pn;

  // Stage 0 captures input_valid even during init_acc; later stages are flushed by it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_p0 <= 1'b0;
      vld_pn <= '0;
    end else begin
      vld_p0    <= input_valid;
      vld_pn[0] <= init_acc ? 1'b0 : vld_p0;
      for (int k = 1; k < MULT_STAGES; k++)
        vld_pn[k] <= init_acc ? 1'b0 : vld_pn[k-1];
    end
  end

  assign idle = ~(vld_p0 | (|vld_pn));

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [INW-1:0]  a;
    logic signed [INW-1:0]  b;
    logic signed [PW-1:0]   mul;
    logic signed [OUTW-1:0] prod_p0;
    logic signed [OUTW-1:0] prod_pn [MULT_STAGES];
    logic signed [OUTW-1:0] acc;
    logic                   ovf;
    logic signed [SW-1:0]   sum;

    assign a   = input0[i*INW +: INW];
    assign b   = input1[i*INW +: INW];
    assign mul = PW'(a) * PW'(b);
    assign sum = SW'(acc) + SW'(prod_pn[MULT_STAGES-1]);

    always_ff @(posedge clk) begin
      if (!reset) begin
        prod_p0 <= '0;
        for (int k = 0; k < MULT_STAGES; k++)
          prod_pn[k] <= '0;
        acc <= '0;
        ovf <= 1'b0;
      end else begin
        // Stage 0: full-width product, sign-extended to accumulator width.
        prod_p0    <= OUTW'(mul);
        prod_pn[0] <= prod_p0;
        for (int k = 1; k < MULT_STAGES; k++)
          prod_pn[k] <= prod_pn[k-1];
        // Accumulate stage: init wins over a landing product.
        if (init_acc) begin
          acc <= init_value;
          ovf <= 1'b0;
        end else if (vld_pn[MULT_STAGES-1]) begin
          acc <= clamp_sum(sum);
          if (sum_ovf(sum))
            ovf <= 1'b1;
        end
      end
    end

    assign out[i*OUTW +: OUTW] = acc;
    assign overflow[i]         = ovf;
  end

endmodule
